dmem_responder: RTL and testbench

Memory-side responder for the core's read/write data-memory port. It serves load and store requests from the load-store stage against an internal word-organised RAM, and returns a right-justified, zero-extended load word that the write-back stage sign-extends as needed. It performs byte-lane steering, checks alignment and range, and can insert a configurable number of wait states. It sits outside the core, at the memory end of the data port.

---
 rtl/dmem_responder.sv | 193 +++++++++++++++++++
 tb/tb_dmem_responder.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder
//   Memory-side responder for the core's data port. Serves byte/half/word
//   loads and stores against an internal word-organised RAM. It steers byte
//   lanes, checks alignment and address range, and returns load data
//   right-justified and zero-extended. WAIT_STATES extra cycles may be
//   inserted between acceptance and response.
//
// Ports
//   clk       in   clock, rising edge
//   rst       in   synchronous reset, active-high
//   req       in   request valid
//   ready     out  request can be accepted this cycle (state == IDLE)
//   write     in   1 = store, 0 = load
//   addr      in   byte address
//   n_bytes   in   0 = byte, 1 = half, 2 = word, 3 = reserved (error)
//   wr_data   in   store data, right-justified
//   ack       out  one-cycle response strobe
//   rd_data   out  load data, right-justified, zero-extended
//   addr_err  out  request rejected, qualified by ack
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  output logic        ready,
  input  logic        write,
  input  logic [31:0] addr,
  input  logic [1:0]  n_bytes,
  input  logic [31:0] wr_data,
  output logic        ack,
  output logic [31:0] rd_data,
  output logic        addr_err
);

  localparam int unsigned IDX_W      = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN_BYTES = 33'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  CNT_INIT   = 4'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;

  // Request captured at acceptance, used when the response is produced late
  logic [31:0]       addr_q;
  logic [1:0]        n_bytes_q;
  logic              write_q;
  logic              err_q;

  logic              ack_q;
  logic [31:0]       rd_data_q;
  logic              addr_err_q;

  logic [31:0]       mem_q [DEPTH_WORDS];

  logic              accept;
  logic              resp_fire;
  logic [31:0]       resp_data;
  logic [31:0]       a_sel;
  logic [1:0]        n_sel;
  logic              w_sel;
  logic              err_sel;
  logic [IDX_W-1:0]  idx_sel;
  logic [3:0]        lane_en;
  logic [31:0]       wdata_sh;

  function automatic logic access_err(input logic [31:0] a, input logic [1:0] n);
    logic [31:0] off;
    logic        bad_align;
    off = a - BASE_ADDR;
    case (n)
      2'd0:    bad_align = 1'b0;
      2'd1:    bad_align = a[0];
      2'd2:    bad_align = (a[1:0] != 2'd0);
      default: bad_align = 1'b1;
    endcase
    // Offset is checked only after ruling out addresses below the base,
    // so the wrapped subtraction never produces a false in-range hit.
    return bad_align || (a < BASE_ADDR) || ({1'b0, off} >= SPAN_BYTES);
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0]  lane,
                                               input logic [1:0]  n);
    logic [31:0] sh;
    sh = word >> {lane, 3'b000};
    case (n)
      2'd0:    return {24'h0, sh[7:0]};
      2'd1:    return {16'h0, sh[15:0]};
      default: return sh;
    endcase
  endfunction

  function automatic logic [3:0] lane_enables(input logic [1:0] n, input logic [1:0] lane);
    case (n)
      2'd0:    return 4'b0001 << lane;
      2'd1:    return 4'b0011 << lane;
      default: return 4'b1111;
    endcase
  endfunction

  // In IDLE the live request is served; in WAIT the captured one is.
  always_comb begin
    accept   = req && (state_q == S_IDLE) && !rst;
    a_sel    = (state_q == S_IDLE) ? addr    : addr_q;
    n_sel    = (state_q == S_IDLE) ? n_bytes : n_bytes_q;
    w_sel    = (state_q == S_IDLE) ? write   : write_q;
    err_sel  = (state_q == S_IDLE) ? access_err(addr, n_bytes) : err_q;
    idx_sel  = IDX_W'((a_sel - BASE_ADDR) >> 2);
    lane_en  = lane_enables(n_sel, a_sel[1:0]);
    wdata_sh = wr_data << {a_sel[1:0], 3'b000};
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept && (WAIT_STATES != 0)) begin
          state_d = S_WAIT;
          cnt_d   = CNT_INIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_IDLE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    ready     = (state_q == S_IDLE);
    resp_fire = ((state_q == S_IDLE) && accept && (WAIT_STATES == 0)) ||
                ((state_q == S_WAIT) && (cnt_q == 4'd0));
    resp_data = (err_sel || w_sel) ? 32'h0
                                   : load_extract(mem_q[idx_sel], a_sel[1:0], n_sel);
    ack       = ack_q;
    rd_data   = rd_data_q;
    addr_err  = addr_err_q;
  end

  // Request capture for delayed responses
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q    <= addr;
      n_bytes_q <= n_bytes;
      write_q   <= write;
      err_q     <= access_err(addr, n_bytes);
    end
  end

  // Stores commit at the acceptance edge regardless of wait states
  always_ff @(posedge clk) begin
    if (accept && write && !err_sel) begin
      for (int b = 0; b < 4; b++) begin
        if (lane_en[b]) mem_q[idx_sel][8*b +: 8] <= wdata_sh[8*b +: 8];
      end
    end
  end

  // Response register; reset drops any pending response
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_q      <= 1'b0;
      rd_data_q  <= 32'h0;
      addr_err_q <= 1'b0;
    end else begin
      ack_q <= resp_fire;
      if (resp_fire) begin
        rd_data_q  <= resp_data;
        addr_err_q <= err_sel;
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder: one instance with no wait states and one
// with three, each checked against a byte-array reference model.
module tb_dmem_responder;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0, req0, write0, ready0, ack0, err0;
  logic [31:0] addr0, wdata0, rd0;
  logic [1:0]  nb0;
  logic        rst3, req3, write3, ready3, ack3, err3;
  logic [31:0] addr3, wdata3, rd3;
  logic [1:0]  nb3;

  int checks = 0;
  int errors = 0;

  logic [7:0] mref0 [4096];
  logic [7:0] mref3 [4096];

  dmem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst0), .req(req0), .ready(ready0), .write(write0),
    .addr(addr0), .n_bytes(nb0), .wr_data(wdata0), .ack(ack0),
    .rd_data(rd0), .addr_err(err0));

  dmem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_STATES(3)) dut3 (
    .clk(clk), .rst(rst3), .req(req3), .ready(ready3), .write(write3),
    .addr(addr3), .n_bytes(nb3), .wr_data(wdata3), .ack(ack3),
    .rd_data(rd3), .addr_err(err3));

  // Reference: memory as a flat byte array, accesses as byte sequences.
  function automatic void model(input bit s, input bit w, input logic [31:0] a,
                                input logic [1:0] n, input logic [31:0] d,
                                output logic [31:0] r, output logic e);
    int sz;
    sz = (n == 2'd0) ? 1 : (n == 2'd1) ? 2 : 4;
    e  = (n == 2'd3) || ((a % sz) != 0) || (a >= 32'd4096);
    r  = 32'h0;
    if (!e) begin
      for (int i = 0; i < sz; i++) begin
        if (w) begin
          if (s) mref3[int'(a) + i] = d[8*i +: 8];
          else   mref0[int'(a) + i] = d[8*i +: 8];
        end else begin
          if (s) r = r | (32'(mref3[int'(a) + i]) << (8*i));
          else   r = r | (32'(mref0[int'(a) + i]) << (8*i));
        end
      end
    end
  endfunction

  // One W=0 transaction; req is left high so calls chain back-to-back.
  task automatic do0(input bit w, input logic [31:0] a, input logic [1:0] n,
                     input logic [31:0] d, output logic k, output logic [31:0] r,
                     output logic e, output logic rdy);
    req0 = 1'b1; write0 = w; addr0 = a; nb0 = n; wdata0 = d;
    rdy = ready0;
    @(posedge clk); #1;
    k = ack0; r = rd0; e = err0;
  endtask

  // One W=3 transaction; returns number of edges after acceptance until ack.
  task automatic do3(input bit w, input logic [31:0] a, input logic [1:0] n,
                     input logic [31:0] d, output logic [31:0] r, output logic e,
                     output int lat);
    req3 = 1'b1; write3 = w; addr3 = a; nb3 = n; wdata3 = d;
    @(posedge clk); #1;
    req3 = 1'b0;
    lat = -1; r = 32'h0; e = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (ack3) begin
        lat = c; r = rd3; e = err3;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst0 = 1'b1; rst3 = 1'b1;
    req0 = 1'b0; write0 = 1'b0; addr0 = '0; nb0 = '0; wdata0 = '0;
    req3 = 1'b0; write3 = 1'b0; addr3 = '0; nb3 = '0; wdata3 = '0;
    repeat (3) @(posedge clk);
    #1;
    rst0 = 1'b0; rst3 = 1'b0;
    checks++;
    if ({ack0, rd0, err0, ready0} !== {1'b0, 32'h0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_w0: ack=%0b rd=%h err=%0b ready=%0b, want 0 0 0 1", ack0, rd0, err0, ready0);
    end
    checks++;
    if ({ack3, rd3, err3, ready3} !== {1'b0, 32'h0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_w3: ack=%0b rd=%h err=%0b ready=%0b, want 0 0 0 1", ack3, rd3, err3, ready3);
    end
  endtask

  // Runs a W=0 op, compares against a fixed value from the plan and the model.
  task automatic op0_fixed(input string nm, input bit w, input logic [31:0] a,
                           input logic [1:0] n, input logic [31:0] d,
                           input logic [31:0] want_r, input logic want_e);
    logic k, e, rdy, me;
    logic [31:0] r, mr;
    model(1'b0, w, a, n, d, mr, me);
    do0(w, a, n, d, k, r, e, rdy);
    checks++;
    if (k !== 1'b1 || rdy !== 1'b1 || r !== want_r || e !== want_e || mr !== want_r || me !== want_e) begin
      errors++;
      $display("FAIL %s: ack=%0b ready=%0b rd=%h err=%0b, want ack=1 ready=1 rd=%h err=%0b",
               nm, k, rdy, r, e, want_r, want_e);
    end
  endtask

  task automatic idle0();
    req0 = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (ack0 !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_ack: ack=%0b, want 0", ack0);
    end
  endtask

  task automatic test_w0_store_load();
    op0_fixed("w0_store", 1'b1, 32'h10, 2'd2, 32'hDEADBEEF, 32'h0, 1'b0);
    op0_fixed("w0_load_next", 1'b0, 32'h10, 2'd2, 32'h0, 32'hDEADBEEF, 1'b0);
    idle0();
  endtask

  task automatic test_byte_merge();
    op0_fixed("byte_store", 1'b1, 32'h11, 2'd0, 32'hFFFFFF55, 32'h0, 1'b0);
    op0_fixed("merge_word", 1'b0, 32'h10, 2'd2, 32'h0, 32'hDEAD55EF, 1'b0);
    op0_fixed("load_byte13", 1'b0, 32'h13, 2'd0, 32'h0, 32'h000000DE, 1'b0);
    op0_fixed("load_half12", 1'b0, 32'h12, 2'd1, 32'h0, 32'h0000DEAD, 1'b0);
    idle0();
  endtask

  task automatic test_align();
    op0_fixed("misalign_word", 1'b0, 32'h12, 2'd2, 32'h0, 32'h0, 1'b1);
    op0_fixed("misalign_half_st", 1'b1, 32'h11, 2'd1, 32'hAAAA, 32'h0, 1'b1);
    op0_fixed("after_bad_store", 1'b0, 32'h10, 2'd2, 32'h0, 32'hDEAD55EF, 1'b0);
    op0_fixed("reserved_size", 1'b0, 32'h10, 2'd3, 32'h0, 32'h0, 1'b1);
    idle0();
  endtask

  task automatic test_range();
    op0_fixed("store_top", 1'b1, 32'hFFC, 2'd2, 32'hCAFEF00D, 32'h0, 1'b0);
    op0_fixed("load_top", 1'b0, 32'hFFC, 2'd2, 32'h0, 32'hCAFEF00D, 1'b0);
    op0_fixed("load_oob", 1'b0, 32'h1000, 2'd2, 32'h0, 32'h0, 1'b1);
    op0_fixed("store_w0", 1'b1, 32'h0, 2'd2, 32'h11111111, 32'h0, 1'b0);
    op0_fixed("store_oob", 1'b1, 32'h1000, 2'd2, 32'h0BADBAD0, 32'h0, 1'b1);
    op0_fixed("no_alias", 1'b0, 32'h0, 2'd2, 32'h0, 32'h11111111, 1'b0);
    idle0();
  endtask

  task automatic test_random_w0();
    logic k, e, rdy, me, w;
    logic [31:0] r, mr, a, d;
    logic [1:0] n;
    for (int i = 0; i < 16; i++) begin
      d = $urandom;
      model(1'b0, 1'b1, 32'h100 + 32'(4*i), 2'd2, d, mr, me);
      do0(1'b1, 32'h100 + 32'(4*i), 2'd2, d, k, r, e, rdy);
      checks++;
      if (k !== 1'b1 || e !== 1'b0 || r !== 32'h0) begin
        errors++;
        $display("FAIL rand0_preload: ack=%0b err=%0b rd=%h, want 1 0 0", k, e, r);
      end
    end
    for (int i = 0; i < 150; i++) begin
      w = 1'($urandom % 2);
      n = 2'($urandom % 4);
      d = $urandom;
      a = (($urandom % 8) == 0) ? 32'h1000 + ($urandom % 64) : 32'h100 + ($urandom % 64);
      model(1'b0, w, a, n, d, mr, me);
      do0(w, a, n, d, k, r, e, rdy);
      checks++;
      if (k !== 1'b1 || rdy !== 1'b1 || r !== mr || e !== me) begin
        errors++;
        $display("FAIL rand0 w=%0b a=%h n=%0d: ack=%0b rd=%h err=%0b, want ack=1 rd=%h err=%0b",
                 w, a, n, k, r, e, mr, me);
      end
    end
    idle0();
  endtask

  task automatic test_w3_timing();
    logic [31:0] mr;
    logic me, want_rdy, want_ack;
    int nack;
    model(1'b1, 1'b1, 32'h40, 2'd2, 32'hA5A5A5A5, mr, me);
    checks++;
    if (ready3 !== 1'b1) begin
      errors++;
      $display("FAIL w3_ready_before: ready=%0b, want 1", ready3);
    end
    req3 = 1'b1; write3 = 1'b1; addr3 = 32'h40; nb3 = 2'd2; wdata3 = 32'hA5A5A5A5;
    nack = 0;
    for (int e = 0; e < 10; e++) begin
      @(posedge clk); #1;
      want_rdy = (e == 3) || (e >= 7);
      want_ack = (e == 3) || (e == 7);
      if (ack3) nack++;
      checks++;
      if (ready3 !== want_rdy || ack3 !== want_ack) begin
        errors++;
        $display("FAIL w3_timing edge %0d: ready=%0b ack=%0b, want ready=%0b ack=%0b",
                 e, ready3, ack3, want_rdy, want_ack);
      end
      if (e == 3) begin
        write3 = 1'b0; wdata3 = 32'h0;
      end
      if (e == 4) req3 = 1'b0;
      if (e == 7) begin
        model(1'b1, 1'b0, 32'h40, 2'd2, 32'h0, mr, me);
        checks++;
        if (rd3 !== 32'hA5A5A5A5 || err3 !== 1'b0 || mr !== 32'hA5A5A5A5) begin
          errors++;
          $display("FAIL w3_held_load: rd=%h err=%0b, want a5a5a5a5 0", rd3, err3);
        end
      end
    end
    checks++;
    if (nack != 2) begin
      errors++;
      $display("FAIL w3_ack_count: got %0d, want 2", nack);
    end
  endtask

  task automatic test_w3_reset_mid_wait();
    logic [31:0] r, mr;
    logic e, me;
    int lat, nack;
    model(1'b1, 1'b1, 32'h20, 2'd2, 32'h12345678, mr, me);
    req3 = 1'b1; write3 = 1'b1; addr3 = 32'h20; nb3 = 2'd2; wdata3 = 32'h12345678;
    @(posedge clk); #1;
    req3 = 1'b0; rst3 = 1'b1;
    @(posedge clk); #1;
    rst3 = 1'b0;
    checks++;
    if ({ack3, rd3, err3, ready3} !== {1'b0, 32'h0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL w3_after_reset: ack=%0b rd=%h err=%0b ready=%0b, want 0 0 0 1",
               ack3, rd3, err3, ready3);
    end
    nack = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (ack3) nack++;
    end
    checks++;
    if (nack != 0) begin
      errors++;
      $display("FAIL w3_dropped_ack: got %0d acks, want 0", nack);
    end
    model(1'b1, 1'b0, 32'h20, 2'd2, 32'h0, mr, me);
    do3(1'b0, 32'h20, 2'd2, 32'h0, r, e, lat);
    checks++;
    if (lat != 3 || r !== 32'h12345678 || e !== 1'b0 || mr !== 32'h12345678) begin
      errors++;
      $display("FAIL w3_store_kept: lat=%0d rd=%h err=%0b, want 3 12345678 0", lat, r, e);
    end
  endtask

  task automatic test_random_w3();
    logic [31:0] r, mr, a, d;
    logic e, me, w;
    logic [1:0] n;
    int lat;
    for (int i = 0; i < 8; i++) begin
      d = $urandom;
      model(1'b1, 1'b1, 32'h200 + 32'(4*i), 2'd2, d, mr, me);
      do3(1'b1, 32'h200 + 32'(4*i), 2'd2, d, r, e, lat);
    end
    for (int i = 0; i < 40; i++) begin
      w = 1'($urandom % 2);
      n = 2'($urandom % 4);
      d = $urandom;
      a = (($urandom % 8) == 0) ? 32'h1000 + ($urandom % 32) : 32'h200 + ($urandom % 32);
      model(1'b1, w, a, n, d, mr, me);
      do3(w, a, n, d, r, e, lat);
      checks++;
      if (lat != 3 || r !== mr || e !== me) begin
        errors++;
        $display("FAIL rand3 w=%0b a=%h n=%0d: lat=%0d rd=%h err=%0b, want lat=3 rd=%h err=%0b",
                 w, a, n, lat, r, e, mr, me);
      end
    end
  endtask

  initial begin
    test_reset();
    test_w0_store_load();
    test_byte_merge();
    test_align();
    test_range();
    test_random_w0();
    test_w3_timing();
    test_w3_reset_mid_wait();
    test_random_w3();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
